// File: rtl/ras_control_pkg.sv
// ras_control_pkg
//   Shared definitions for the fetch-side return-address-stack controller:
//   RISC-V opcode constants, link-register numbers, controller state
//   encoding, the default number of outstanding speculative branches and
//   the link-register test used by the hint decoder.
package ras_control_pkg;

  // Must match the depth of the RAS index FIFO.
  localparam int unsigned MAX_IDS_DEFAULT = 4;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [4:0] REG_X1 = 5'd1;
  localparam logic [4:0] REG_X5 = 5'd5;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ras_ctrl_state_t;

  // x1 (ra) and x5 (t0) are the two registers the ISA hints treat as links.
  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_X1) || (r == REG_X5);
  endfunction

endpackage

// File: rtl/ras_control_hint_decode.sv
// ras_control_hint_decode
//   Purely combinational RAS hint decoder. Classifies one instruction word
//   according to the link-register hint table.
//   Ports:
//     instr          in   32  raw instruction word
//     is_push        out  1   instruction pushes a return address
//     is_pop         out  1   instruction pops a return address
//     is_spec_branch out  1   instruction is a speculative branch (BRANCH/JALR)
module ras_control_hint_decode
  import ras_control_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_push,
  output logic        is_pop,
  output logic        is_spec_branch
);

  logic [6:0] opcode_s;
  logic [4:0] rd_s;
  logic [4:0] rs1_s;
  logic [2:0] funct3_s;
  logic       rd_link_s;
  logic       rs1_link_s;
  logic       unused_bits_s;

  assign opcode_s   = instr[6:0];
  assign rd_s       = instr[11:7];
  assign funct3_s   = instr[14:12];
  assign rs1_s      = instr[19:15];
  assign rd_link_s  = is_link(rd_s);
  assign rs1_link_s = is_link(rs1_s);

  // Immediate and rs2 fields carry no hint information.
  assign unused_bits_s = ^instr[31:20];

  // Hint table: JAL never speculative; JALR with two distinct links is a
  // coroutine swap (push and pop together, RAS overwrites its top).
  always_comb begin
    is_push        = 1'b0;
    is_pop         = 1'b0;
    is_spec_branch = 1'b0;
    case (opcode_s)
      OPC_JAL: begin
        is_push = rd_link_s;
      end
      OPC_JALR: begin
        if (funct3_s == F3_JALR) begin
          is_spec_branch = 1'b1;
          is_push        = rd_link_s;
          if (rs1_link_s && (!rd_link_s || (rd_s != rs1_s))) begin
            is_pop = 1'b1;
          end else begin
            is_pop = 1'b0;
          end
        end else begin
          is_spec_branch = 1'b0;
        end
      end
      OPC_BRANCH: begin
        is_spec_branch = 1'b1;
      end
      default: begin
        is_push        = 1'b0;
        is_pop         = 1'b0;
        is_spec_branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ras_control.sv
// ras_control
//   Fetch-side driver of the return-address-stack interface. Decodes each
//   accepted fetch instruction into RAS push/pop/branch strobes, tracks the
//   number of outstanding speculative branches, stalls fetch when the RAS
//   index FIFO is full and registers the predicted return target.
//   Ports:
//     clk, rst (async active-low)
//     fetch_valid/fetch_accept/fetch_pc/fetch_instr  fetch stage handshake
//     branch_retire   oldest speculative branch resolved
//     gc_fetch_flush  mispredict / global flush
//     ras_addr        current RAS top-of-stack
//     ras_push/ras_pop/ras_new_addr/ras_branch_fetched/ras_branch_retired
//                     RAS control strobes (combinational)
//     pred_ret_valid/pred_ret_addr  registered return prediction
//     fetch_stall, outstanding, retire_underflow  status
module ras_control
  import ras_control_pkg::*;
#(
  parameter int unsigned MAX_IDS = MAX_IDS_DEFAULT,
  parameter int unsigned ADDR_W  = 32,
  localparam int unsigned CNT_W  = $clog2(MAX_IDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic              fetch_accept,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [31:0]       fetch_instr,
  input  logic              branch_retire,
  input  logic              gc_fetch_flush,
  input  logic [ADDR_W-1:0] ras_addr,
  output logic              ras_push,
  output logic              ras_pop,
  output logic [ADDR_W-1:0] ras_new_addr,
  output logic              ras_branch_fetched,
  output logic              ras_branch_retired,
  output logic              pred_ret_valid,
  output logic [ADDR_W-1:0] pred_ret_addr,
  output logic              fetch_stall,
  output logic [CNT_W-1:0]  outstanding,
  output logic              retire_underflow
);

  ras_ctrl_state_t   state_r;
  ras_ctrl_state_t   state_next_s;
  logic              run_s;
  logic              fire_s;
  logic              stall_s;
  logic              dec_push_s;
  logic              dec_pop_s;
  logic              dec_spec_s;
  logic              fetched_s;
  logic              retired_s;
  logic              underflow_s;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  outstanding_next_s;
  logic              pred_valid_r;
  logic [ADDR_W-1:0] pred_addr_r;
  logic              underflow_r;

  ras_control_hint_decode u_hint_decode (
    .instr          (fetch_instr),
    .is_push        (dec_push_s),
    .is_pop         (dec_pop_s),
    .is_spec_branch (dec_spec_s)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: any flush enters RECOVER; RECOVER lasts one cycle unless re-flushed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (gc_fetch_flush) state_next_s = RECOVER;
        else                state_next_s = RUN;
      end
      RECOVER: begin
        if (gc_fetch_flush) state_next_s = RECOVER;
        else                state_next_s = RUN;
      end
      default: state_next_s = RUN;
    endcase
  end

  // State decode: fetch and retire tracking are only live in RUN.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      RUN:     run_s = 1'b1;
      RECOVER: run_s = 1'b0;
      default: run_s = 1'b0;
    endcase
  end

  assign stall_s = (outstanding_r == CNT_W'(MAX_IDS));

  // rst is folded in so every strobe is low while reset is held.
  assign fire_s = rst & fetch_valid & fetch_accept & ~stall_s & run_s & ~gc_fetch_flush;

  assign fetched_s   = fire_s & dec_spec_s;
  assign retired_s   = rst & run_s & branch_retire & (outstanding_r != '0) & ~gc_fetch_flush;
  assign underflow_s = rst & run_s & branch_retire & (outstanding_r == '0) & ~gc_fetch_flush;

  // Outstanding-branch count: flush and RECOVER force zero, otherwise +fetch -retire.
  always_comb begin
    outstanding_next_s = outstanding_r;
    if (gc_fetch_flush || !run_s) begin
      outstanding_next_s = '0;
    end else begin
      case ({fetched_s, retired_s})
        2'b10:   outstanding_next_s = outstanding_r + CNT_W'(1);
        2'b01:   outstanding_next_s = outstanding_r - CNT_W'(1);
        default: outstanding_next_s = outstanding_r;
      endcase
    end
  end

  // Outstanding-branch count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding_r <= '0;
    end else begin
      outstanding_r <= outstanding_next_s;
    end
  end

  // Return prediction: capture top-of-stack before it is popped; valid is a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_r <= 1'b0;
      pred_addr_r  <= '0;
    end else if (gc_fetch_flush) begin
      pred_valid_r <= 1'b0;
    end else if (fire_s && dec_pop_s) begin
      pred_valid_r <= 1'b1;
      pred_addr_r  <= ras_addr;
    end else begin
      pred_valid_r <= 1'b0;
    end
  end

  // Sticky retire-underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_r <= 1'b0;
    end else if (underflow_s) begin
      underflow_r <= 1'b1;
    end else begin
      underflow_r <= underflow_r;
    end
  end

  assign ras_push           = fire_s & dec_push_s;
  assign ras_pop            = fire_s & dec_pop_s;
  assign ras_branch_fetched = fetched_s;
  assign ras_branch_retired = retired_s;
  assign ras_new_addr       = fetch_pc + ADDR_W'(4);
  assign pred_ret_valid     = pred_valid_r;
  assign pred_ret_addr      = pred_addr_r;
  assign fetch_stall        = stall_s;
  assign outstanding        = outstanding_r;
  assign retire_underflow   = underflow_r;

endmodule

// File: tb/tb_ras_control.sv
// tb_ras_control
//   Directed-vector scoreboard bench for ras_control. The driver applies one
//   vector per cycle and queues the hand-computed outputs expected in that
//   cycle; a monitor on the falling edge pops and compares them.
module tb_ras_control;

  localparam logic [31:0] I_JAL1  = 32'h0000_00EF; // jal   x1, 0
  localparam logic [31:0] I_RET   = 32'h0000_8067; // jalr  x0, 0(x1)
  localparam logic [31:0] I_COR   = 32'h0000_82E7; // jalr  x5, 0(x1)
  localparam logic [31:0] I_CALLR = 32'h0000_80E7; // jalr  x1, 0(x1)
  localparam logic [31:0] I_BEQ   = 32'h0000_0063; // beq   x0, x0, 0
  localparam logic [31:0] I_NOP   = 32'h0000_0013; // addi  x0, x0, 0

  typedef struct {
    logic        push;
    logic        pop;
    logic        bf;
    logic        br;
    logic        chk_addr;
    logic [31:0] new_addr;
    logic        stall;
    logic [2:0]  outs;
    logic        prv;
    logic [31:0] pra;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_accept = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic [31:0] fetch_instr = 32'h0;
  logic        branch_retire = 1'b0;
  logic        gc_fetch_flush = 1'b0;
  logic [31:0] ras_addr = 32'h0;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_new_addr;
  logic        ras_branch_fetched;
  logic        ras_branch_retired;
  logic        pred_ret_valid;
  logic [31:0] pred_ret_addr;
  logic        fetch_stall;
  logic [2:0]  outstanding;
  logic        retire_underflow;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  ras_control #(.MAX_IDS(4), .ADDR_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid        (fetch_valid),
    .fetch_accept       (fetch_accept),
    .fetch_pc           (fetch_pc),
    .fetch_instr        (fetch_instr),
    .branch_retire      (branch_retire),
    .gc_fetch_flush     (gc_fetch_flush),
    .ras_addr           (ras_addr),
    .ras_push           (ras_push),
    .ras_pop            (ras_pop),
    .ras_new_addr       (ras_new_addr),
    .ras_branch_fetched (ras_branch_fetched),
    .ras_branch_retired (ras_branch_retired),
    .pred_ret_valid     (pred_ret_valid),
    .pred_ret_addr      (pred_ret_addr),
    .fetch_stall        (fetch_stall),
    .outstanding        (outstanding),
    .retire_underflow   (retire_underflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic push, input logic pop, input logic bf,
                              input logic br, input logic chk_addr,
                              input logic [31:0] new_addr, input logic stall,
                              input logic [2:0] outs, input logic prv,
                              input logic [31:0] pra, input logic uf);
    exp_t e;
    e.push = push; e.pop = pop; e.bf = bf; e.br = br;
    e.chk_addr = chk_addr; e.new_addr = new_addr; e.stall = stall;
    e.outs = outs; e.prv = prv; e.pra = pra; e.uf = uf;
    return e;
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", n, name, act, req);
    end
  endtask

  // Apply one vector just after the rising edge and queue its expected outputs.
  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ret, input logic fl,
                       input logic [31:0] ra, input exp_t e);
    @(posedge clk);
    #1;
    rst            = r;
    fetch_valid    = v;
    fetch_accept   = v;
    fetch_pc       = pc;
    fetch_instr    = instr;
    branch_retire  = ret;
    gc_fetch_flush = fl;
    ras_addr       = ra;
    exp_q.push_back(e);
  endtask

  task automatic idle(input exp_t e);
    drive(1'b1, 1'b0, 32'h0, I_NOP, 1'b0, 1'b0, 32'h0, e);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vec_no++;
      chk("ras_push",           vec_no, 32'(ras_push),           32'(e.push));
      chk("ras_pop",            vec_no, 32'(ras_pop),            32'(e.pop));
      chk("ras_branch_fetched", vec_no, 32'(ras_branch_fetched), 32'(e.bf));
      chk("ras_branch_retired", vec_no, 32'(ras_branch_retired), 32'(e.br));
      if (e.chk_addr) chk("ras_new_addr", vec_no, ras_new_addr, e.new_addr);
      chk("fetch_stall",        vec_no, 32'(fetch_stall),        32'(e.stall));
      chk("outstanding",        vec_no, 32'(outstanding),        32'(e.outs));
      chk("pred_ret_valid",     vec_no, 32'(pred_ret_valid),     32'(e.prv));
      chk("pred_ret_addr",      vec_no, pred_ret_addr,           e.pra);
      chk("retire_underflow",   vec_no, 32'(retire_underflow),   32'(e.uf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    // Reset held: strobes low even with a firing call.
    drive(1'b0, 1'b1, 32'h100, I_JAL1, 1'b0, 1'b0, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h0,0));
    // Call / return / coroutine / indirect call.
    drive(1'b1, 1'b1, 32'h100, I_JAL1,  1'b0, 1'b0, 32'h0,   mk(1,0,0,0,1,32'h104,0,3'd0,0,32'h0,0));
    drive(1'b1, 1'b1, 32'h104, I_RET,   1'b0, 1'b0, 32'h104, mk(0,1,1,0,0,32'h0,0,3'd0,0,32'h0,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd1,1,32'h104,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd1,0,32'h104,0));
    drive(1'b1, 1'b1, 32'h200, I_COR,   1'b0, 1'b0, 32'h300, mk(1,1,1,0,1,32'h204,0,3'd1,0,32'h104,0));
    drive(1'b1, 1'b1, 32'h210, I_CALLR, 1'b0, 1'b0, 32'h204, mk(1,0,1,0,1,32'h214,0,3'd2,1,32'h300,0));
    // Drain the three outstanding branches.
    drive(1'b1, 1'b0, 32'h0, I_NOP, 1'b1, 1'b0, 32'h0, mk(0,0,0,1,0,32'h0,0,3'd3,0,32'h300,0));
    drive(1'b1, 1'b0, 32'h0, I_NOP, 1'b1, 1'b0, 32'h0, mk(0,0,0,1,0,32'h0,0,3'd2,0,32'h300,0));
    drive(1'b1, 1'b0, 32'h0, I_NOP, 1'b1, 1'b0, 32'h0, mk(0,0,0,1,0,32'h0,0,3'd1,0,32'h300,0));
    // Fill to MAX_IDS, then a stalled fifth branch.
    drive(1'b1, 1'b1, 32'h400, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,1,0,0,32'h0,0,3'd0,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h404, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,1,0,0,32'h0,0,3'd1,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h408, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,1,0,0,32'h0,0,3'd2,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h40C, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,1,0,0,32'h0,0,3'd3,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h410, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,0,0,0,32'h0,1,3'd4,0,32'h300,0));
    drive(1'b1, 1'b0, 32'h0,   I_NOP, 1'b1, 1'b0, 32'h0, mk(0,0,0,1,0,32'h0,1,3'd4,0,32'h300,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd3,0,32'h300,0));
    drive(1'b1, 1'b0, 32'h0,   I_NOP, 1'b1, 1'b0, 32'h0, mk(0,0,0,1,0,32'h0,0,3'd3,0,32'h300,0));
    // Fetch and retire together at count 2.
    drive(1'b1, 1'b1, 32'h420, I_BEQ, 1'b1, 1'b0, 32'h0, mk(0,0,1,1,0,32'h0,0,3'd2,0,32'h300,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd2,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h424, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,1,0,0,32'h0,0,3'd2,0,32'h300,0));
    // Flush at count 3 with concurrent fire and retire.
    drive(1'b1, 1'b1, 32'h428, I_BEQ,  1'b1, 1'b1, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd3,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h500, I_JAL1, 1'b1, 1'b0, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h500, I_JAL1, 1'b0, 1'b0, 32'h0, mk(1,0,0,0,1,32'h504,0,3'd0,0,32'h300,0));
    // Back-to-back flushes hold RECOVER.
    drive(1'b1, 1'b0, 32'h0,   I_NOP,  1'b0, 1'b1, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    drive(1'b1, 1'b0, 32'h0,   I_NOP,  1'b0, 1'b1, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h580, I_JAL1, 1'b0, 1'b0, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    drive(1'b1, 1'b1, 32'h600, I_JAL1, 1'b0, 1'b0, 32'h0, mk(1,0,0,0,1,32'h604,0,3'd0,0,32'h300,0));
    // Return coincident with flush: no pop, no prediction.
    drive(1'b1, 1'b1, 32'h700, I_RET,  1'b0, 1'b1, 32'h700, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    // Retire at count 0: sticky underflow.
    drive(1'b1, 1'b0, 32'h0, I_NOP, 1'b1, 1'b0, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,1));
    idle(mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h300,1));
    // Build state, then asynchronous reset mid-stream.
    drive(1'b1, 1'b1, 32'h800, I_BEQ, 1'b0, 1'b0, 32'h0,   mk(0,0,1,0,0,32'h0,0,3'd0,0,32'h300,1));
    drive(1'b1, 1'b1, 32'h804, I_RET, 1'b0, 1'b0, 32'h800, mk(0,1,1,0,0,32'h0,0,3'd1,0,32'h300,1));
    idle(mk(0,0,0,0,0,32'h0,0,3'd2,1,32'h800,1));
    drive(1'b0, 1'b1, 32'h808, I_BEQ, 1'b0, 1'b0, 32'h0, mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h0,0));
    // Push address wraps at the top of the address space.
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, I_JAL1, 1'b0, 1'b0, 32'h0, mk(1,0,0,0,1,32'h0,0,3'd0,0,32'h0,0));
    idle(mk(0,0,0,0,0,32'h0,0,3'd0,0,32'h0,0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
